// File: rtl/cde_jtag_tap_ctrl_multi.sv
// ---------------------------------------------------------------------------
// cde_jtag_tap_ctrl_multi
//
// IEEE 1149.1 TAP controller for a single JTAG port. It contains the 16-state
// TAP FSM, a parametrised-length instruction register, the bypass and IDCODE
// registers, boundary-scan mode decode, and NUM_USER user data-register
// channels with TDO multiplexing and retiming.
//
// Ports:
//   clk              TCK; every flop uses the rising edge
//   reset            synchronous active-high reset (TRST equivalent)
//   tms, tdi         JTAG mode select / serial data in
//   tdo, tdo_oe      registered serial data out and its pad enable
//   instruction      active instruction
//   test_logic_reset FSM is in Test-Logic-Reset
//   capture_dr       FSM is in Capture-DR
//   shift_dr         FSM is in Shift-DR
//   update_dr        FSM is in Update-DR
//   user_select      one-hot active user DR channel
//   user_tdo_i       serial outputs of the user DRs
//   bsr_select       EXTEST or SAMPLE active
//   bsr_tdo_i        boundary scan register serial out
//   extest, sample,
//   clamp, highz     instruction decode flags
//   tdi_o            tdi passthrough to the DR chain
// ---------------------------------------------------------------------------
module cde_jtag_tap_ctrl_multi #(
    parameter int unsigned            INST_LENGTH = 4,
    parameter int unsigned            NUM_USER    = 2,
    parameter logic [INST_LENGTH-1:0] USER_BASE   = 4'b1001,
    parameter logic [INST_LENGTH-1:0] INST_RESET  = 4'b1111,
    parameter logic [INST_LENGTH-1:0] BYPASS      = 4'b1111,
    parameter logic [INST_LENGTH-1:0] IDCODE      = 4'b0011,
    parameter logic [INST_LENGTH-1:0] EXTEST      = 4'b0000,
    parameter logic [INST_LENGTH-1:0] SAMPLE      = 4'b0001,
    parameter logic [INST_LENGTH-1:0] CLAMP       = 4'b1000,
    parameter logic [INST_LENGTH-1:0] HIGHZ       = 4'b0010,
    parameter logic [31:0]            CHIP_ID_VAL = 32'h0000_0001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tms,
    input  logic                   tdi,
    output logic                   tdo,
    output logic                   tdo_oe,
    output logic [INST_LENGTH-1:0] instruction,
    output logic                   test_logic_reset,
    output logic                   capture_dr,
    output logic                   shift_dr,
    output logic                   update_dr,
    output logic [NUM_USER-1:0]    user_select,
    input  logic [NUM_USER-1:0]    user_tdo_i,
    output logic                   bsr_select,
    input  logic                   bsr_tdo_i,
    output logic                   extest,
    output logic                   sample,
    output logic                   clamp,
    output logic                   highz,
    output logic                   tdi_o
);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR_SCAN,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR_SCAN,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_state_t;

    // Fixed 1149.1 capture pattern for the IR: ...0001.
    localparam logic [INST_LENGTH-1:0] IR_CAPTURE = INST_LENGTH'(2'b01);
    // IDCODE bit 0 must always read as 1.
    localparam logic [31:0]            ID_CAPTURE = CHIP_ID_VAL | 32'h1;

    tap_state_t             state_q;
    tap_state_t             state_d;
    logic                   in_shift_ir;
    logic                   in_shift_dr;

    logic [INST_LENGTH-1:0] ir_shift_q;
    logic [INST_LENGTH-1:0] instruction_q;
    logic                   bypass_q;
    logic [31:0]            id_q;

    logic                   hit_bypass;
    logic                   hit_idcode;
    logic                   hit_extest;
    logic                   hit_sample;
    logic                   hit_clamp;
    logic                   hit_highz;
    logic                   fixed_hit;
    logic                   user_taken;
    logic [NUM_USER-1:0]    user_sel;
    logic                   tdo_mux;

    // -----------------------------------------------------------------------
    // TAP FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        test_logic_reset = 1'b0;
        capture_dr       = 1'b0;
        shift_dr         = 1'b0;
        update_dr        = 1'b0;
        in_shift_ir      = 1'b0;
        in_shift_dr      = 1'b0;

        case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase

        test_logic_reset = (state_q == TEST_LOGIC_RESET);
        capture_dr       = (state_q == CAPTURE_DR);
        shift_dr         = (state_q == SHIFT_DR);
        update_dr        = (state_q == UPDATE_DR);
        in_shift_ir      = (state_q == SHIFT_IR);
        in_shift_dr      = (state_q == SHIFT_DR);
    end

    // -----------------------------------------------------------------------
    // Instruction register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_shift_q    <= '0;
            instruction_q <= INST_RESET;
        end else begin
            if (state_q == CAPTURE_IR) begin
                ir_shift_q <= IR_CAPTURE;
            end else if (state_q == SHIFT_IR) begin
                ir_shift_q <= {tdi, ir_shift_q[INST_LENGTH-1:1]};
            end

            if (state_q == TEST_LOGIC_RESET) begin
                instruction_q <= INST_RESET;
            end else if (state_q == UPDATE_IR) begin
                instruction_q <= ir_shift_q;
            end
        end
    end

    // The override makes reset take effect on the active instruction
    // immediately rather than one edge later.
    always_comb begin
        instruction = instruction_q;
        if (reset || (state_q == TEST_LOGIC_RESET)) begin
            instruction = INST_RESET;
        end
    end

    // -----------------------------------------------------------------------
    // Instruction decode. Fixed opcodes win over user channels, in the order
    // BYPASS, IDCODE, EXTEST, SAMPLE, CLAMP, HIGHZ; among user channels the
    // lowest index wins so user_select stays one-hot if opcodes wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        hit_bypass = (instruction == BYPASS);
        hit_idcode = (instruction == IDCODE) && !hit_bypass;
        hit_extest = (instruction == EXTEST) && !hit_bypass && !hit_idcode;
        hit_sample = (instruction == SAMPLE) && !hit_bypass && !hit_idcode
                     && !hit_extest;
        hit_clamp  = (instruction == CLAMP)  && !hit_bypass && !hit_idcode
                     && !hit_extest && !hit_sample;
        hit_highz  = (instruction == HIGHZ)  && !hit_bypass && !hit_idcode
                     && !hit_extest && !hit_sample && !hit_clamp;
        fixed_hit  = hit_bypass | hit_idcode | hit_extest | hit_sample
                     | hit_clamp | hit_highz;

        user_sel   = '0;
        user_taken = fixed_hit;
        for (int unsigned k = 0; k < NUM_USER; k++) begin
            if (!user_taken && (instruction == USER_BASE + INST_LENGTH'(k))) begin
                user_sel[k] = 1'b1;
                user_taken  = 1'b1;
            end
        end
    end

    assign extest      = hit_extest;
    assign sample      = hit_sample;
    assign clamp       = hit_clamp;
    assign highz       = hit_highz;
    assign bsr_select  = hit_extest | hit_sample;
    assign user_select = user_sel;
    assign tdi_o       = tdi;

    // -----------------------------------------------------------------------
    // Bypass and IDCODE data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bypass_q <= 1'b0;
            id_q     <= '0;
        end else begin
            if (state_q == CAPTURE_DR) begin
                bypass_q <= 1'b0;
                if (hit_idcode) begin
                    id_q <= ID_CAPTURE;
                end
            end else if (state_q == SHIFT_DR) begin
                bypass_q <= tdi;
                if (hit_idcode) begin
                    id_q <= {tdi, id_q[31:1]};
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // TDO source selection and retiming
    // -----------------------------------------------------------------------
    always_comb begin
        tdo_mux = bypass_q;
        if (in_shift_ir) begin
            tdo_mux = ir_shift_q[0];
        end else if (hit_idcode) begin
            tdo_mux = id_q[0];
        end else if (hit_extest || hit_sample) begin
            tdo_mux = bsr_tdo_i;
        end else if (|user_sel) begin
            tdo_mux = |(user_sel & user_tdo_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else begin
            tdo_oe <= in_shift_ir | in_shift_dr;
            tdo    <= (in_shift_ir | in_shift_dr) ? tdo_mux : 1'b0;
        end
    end

endmodule

// File: tb/tb_cde_jtag_tap_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_cde_jtag_tap_ctrl_multi
//
// Self-checking bench for cde_jtag_tap_ctrl_multi. Expected TDO bits are
// queued when a shift cycle is driven and compared when the registered TDO
// appears; state and decode outputs are compared directly.
// ---------------------------------------------------------------------------
module tb_cde_jtag_tap_ctrl_multi;

    localparam int unsigned IL      = 4;
    localparam int unsigned NU      = 2;
    localparam logic [31:0] CHIP_ID = 32'h1234_5678;
    localparam logic [31:0] ID_EXP  = 32'h1234_5679;

    logic          clk;
    logic          reset;
    logic          tms;
    logic          tdi;
    logic          tdo;
    logic          tdo_oe;
    logic [IL-1:0] instruction;
    logic          test_logic_reset;
    logic          capture_dr;
    logic          shift_dr;
    logic          update_dr;
    logic [NU-1:0] user_select;
    logic [NU-1:0] user_tdo_i;
    logic          bsr_select;
    logic          bsr_tdo_i;
    logic          extest;
    logic          sample;
    logic          clamp;
    logic          highz;
    logic          tdi_o;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic          exp_q[$];
    bit            mon_en   = 1'b0;

    cde_jtag_tap_ctrl_multi #(
        .INST_LENGTH (IL),
        .NUM_USER    (NU),
        .USER_BASE   (4'b1001),
        .INST_RESET  (4'b1111),
        .BYPASS      (4'b1111),
        .IDCODE      (4'b0011),
        .EXTEST      (4'b0000),
        .SAMPLE      (4'b0001),
        .CLAMP       (4'b1000),
        .HIGHZ       (4'b0010),
        .CHIP_ID_VAL (CHIP_ID)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .tms              (tms),
        .tdi              (tdi),
        .tdo              (tdo),
        .tdo_oe           (tdo_oe),
        .instruction      (instruction),
        .test_logic_reset (test_logic_reset),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .user_select      (user_select),
        .user_tdo_i       (user_tdo_i),
        .bsr_select       (bsr_select),
        .bsr_tdo_i        (bsr_tdo_i),
        .extest           (extest),
        .sample           (sample),
        .clamp            (clamp),
        .highz            (highz),
        .tdi_o            (tdi_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Inputs change on the falling edge; the task returns just after the
    // following rising edge so outputs can be inspected.
    task automatic drive(input logic t_ms, input logic t_di);
        @(negedge clk);
        tms = t_ms;
        tdi = t_di;
        @(posedge clk);
        #2;
    endtask

    // From Run-Test/Idle; ends in Run-Test/Idle with op as the instruction.
    task automatic load_ir(input logic [IL-1:0] op);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        for (int i = 0; i < int'(IL); i++) begin
            exp_q.push_back(i == 0);
            drive(i == int'(IL) - 1, op[i]);
        end
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("instruction", 32'(instruction), 32'(op));
    endtask

    task automatic enter_shift_dr();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic exit_dr();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    // TDO monitor: every cycle with tdo_oe must match the next queued bit,
    // and tdo must be 0 whenever the enable is low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (tdo_oe) begin
                    if (exp_q.size() == 0) begin
                        check("tdo_unexpected", 32'(tdo_oe), 32'd0);
                    end else begin
                        check("tdo", 32'(tdo), 32'(exp_q.pop_front()));
                    end
                end else begin
                    check("tdo_idle", 32'(tdo), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          prev;
        logic [3:0]    pat;
        logic [2:0]    byp;
        int unsigned   upd_cnt;

        reset      = 1'b1;
        tms        = 1'b1;
        tdi        = 1'b0;
        user_tdo_i = '0;
        bsr_tdo_i  = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check("rst_tlr", 32'(test_logic_reset), 32'd1);
        check("rst_tdo_oe", 32'(tdo_oe), 32'd0);
        check("rst_instr", 32'(instruction), 32'hF);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        repeat (5) drive(1'b0, 1'b0);
        check("rti_tlr", 32'(test_logic_reset), 32'd0);
        check("rti_state", 32'({capture_dr, shift_dr, update_dr}), 32'd0);
        check("rti_instr", 32'(instruction), 32'hF);
        check("rti_tdo_oe", 32'(tdo_oe), 32'd0);
        check("rti_user", 32'(user_select), 32'd0);
        check("rti_bsr", 32'(bsr_select), 32'd0);
        tdi = 1'b1;
        #1;
        check("tdi_o", 32'(tdi_o), 32'd1);
        tdi = 1'b0;

        // IDCODE: bit 0 forced high, LSB first
        load_ir(4'b0011);
        check("idcode_user", 32'(user_select), 32'd0);
        enter_shift_dr();
        check("shift_dr_flag", 32'(shift_dr), 32'd1);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(ID_EXP[i]);
            drive(i == 31, 1'($urandom_range(0, 1)));
        end
        exit_dr();

        // Boundary-scan modes
        load_ir(4'b0000);
        check("extest", 32'({extest, sample, clamp, highz, bsr_select}), 32'b10001);
        enter_shift_dr();
        for (int i = 0; i < 2; i++) begin
            bsr_tdo_i = (i == 1);
            exp_q.push_back(i == 1);
            drive(i == 1, 1'b0);
        end
        bsr_tdo_i = 1'b0;
        exit_dr();
        load_ir(4'b0001);
        check("sample", 32'({extest, sample, clamp, highz, bsr_select}), 32'b01001);
        load_ir(4'b1000);
        check("clamp", 32'({extest, sample, clamp, highz, bsr_select}), 32'b00100);
        load_ir(4'b0010);
        check("highz", 32'({extest, sample, clamp, highz, bsr_select}), 32'b00010);

        // User channels
        load_ir(4'b1001);
        check("user0_sel", 32'(user_select), 32'b01);
        load_ir(4'b1010);
        check("user1_sel", 32'(user_select), 32'b10);
        pat = 4'b1101;
        enter_shift_dr();
        for (int i = 0; i < 4; i++) begin
            user_tdo_i = {pat[i], ~pat[i]};
            exp_q.push_back(pat[i]);
            drive(i == 3, 1'b0);
        end
        user_tdo_i = '0;
        exit_dr();

        // Unmatched opcode behaves as bypass
        load_ir(4'b0101);
        check("unmatched_sel", 32'({user_select, bsr_select}), 32'd0);
        prev = 1'b0;
        enter_shift_dr();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(prev);
            prev = (i == 0);
            drive(i == 1, i == 0);
        end
        exit_dr();

        // BYPASS: tdi 1,1,0 -> tdo 0,1,1
        load_ir(4'b1111);
        byp  = 3'b011;
        prev = 1'b0;
        enter_shift_dr();
        check("capture_exit", 32'(capture_dr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(prev);
            prev = byp[i];
            drive(i == 2, byp[i]);
        end
        exit_dr();

        // Five tms=1 cycles from Shift-DR reach Test-Logic-Reset
        enter_shift_dr();
        exp_q.push_back(1'b0);
        upd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            if (update_dr) upd_cnt++;
        end
        check("tms5_tlr", 32'(test_logic_reset), 32'd1);
        check("tlr_upd_cap", 32'({update_dr, capture_dr}), 32'd0);
        check("tlr_instr", 32'(instruction), 32'hF);
        check("tms5_update_visits", upd_cnt, 32'd1);

        // Reset in the middle of Shift-IR
        drive(1'b0, 1'b0);
        load_ir(4'b1010);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        exp_q.push_back(1'b1);
        drive(1'b0, 1'b1);
        exp_q.push_back(1'b0);
        drive(1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        tms   = 1'b0;
        #1;
        check("rst_mid_instr_now", 32'(instruction), 32'hF);
        @(posedge clk);
        #2;
        check("rst_mid_tlr", 32'(test_logic_reset), 32'd1);
        check("rst_mid_tdo_oe", 32'(tdo_oe), 32'd0);
        check("rst_mid_instr", 32'(instruction), 32'hF);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0);
        check("post_rst_instr", 32'(instruction), 32'hF);
        check("post_rst_user", 32'(user_select), 32'd0);

        repeat (2) drive(1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
